fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch front end that produces the 32-bit instruction stream consumed by the core's instruction decoder. Holds the PC, issues in-order requests to instruction memory, buffers returned words with their PCs in a small queue, and presents them to decode over a valid/ready handshake. A branch/JALR redirect from the back end flushes the queue and discards in-flight responses.

## Interface
- RESET_PC, 32'h0000_0000, PC of the first fetch after reset
- DEPTH, 4, instruction-queue entries; power of two, ≥2
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- imem_req_valid  out  1  request to instruction memory
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  fetch address, word-aligned
- imem_resp_valid  in  1  one returned word, strictly in request order, latency ≥1 cycle
- imem_resp_data  in  32  returned instruction
- redirect_valid  in  1  single-cycle control-flow redirect
- redirect_pc  in  32  new fetch PC; bits [1:0] ignored, forced to 0
- out_valid  out  1  instruction available to decode
- out_ready  in  1  decode accepts instruction
- out_instr  out  32  instruction word
- out_pc  out  32  PC of out_instr

## Operation
- Registers: fetch_pc (next request address), resp_pc (PC of next expected response), outstanding count (0..DEPTH), drop count (0..DEPTH), queue of {pc, instr}.
- Credit rule: imem_req_valid=1 only in RUN and when outstanding + queue_count < DEPTH; this guarantees every response has a free slot, so the memory is never back-pressured.
- Request handshake (valid & ready): fetch_pc += 4, outstanding += 1.
- Response: if drop count > 0, discard and decrement it; otherwise push {resp_pc, imem_resp_data}, resp_pc += 4, outstanding −= 1.
- Decode handshake (out_valid & out_ready): pop head.
- Redirect: queue cleared; fetch_pc and resp_pc ← {redirect_pc[31:2],2'b00}; drop count ← all in-flight requests (outstanding, plus 1 if a request handshake occurs the same cycle, minus 1 if a non-dropped response arrives the same cycle); outstanding ← 0. A response arriving in the redirect cycle is never enqueued.
- FSM: IDLE (entered on reset; one cycle, no requests) → RUN. RUN → FLUSH on redirect when the new drop count > 0; FLUSH blocks requests and returns to RUN in the cycle after drop count reaches 0. Redirect in FLUSH stays in FLUSH and reloads PCs.
- PC arithmetic is modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0 without error.
- Simultaneous push and pop on a full queue is legal; count unchanged.

## Timing
- Reset values: imem_req_valid=0, imem_req_addr=RESET_PC, out_valid=0, out_instr=0, out_pc=0; state IDLE, all counts 0.
- First request is asserted in the second cycle after rst_n deasserts (IDLE for one cycle).
- imem_req_addr is stable while imem_req_valid=1 and imem_req_ready=0.
- Response-to-output latency: one cycle (word written at edge N, out_valid high after edge N).
- Pop-to-next-head: next entry visible the cycle after pop; back-to-back pops sustain 1 instr/cycle.
- Redirect takes effect at the edge it is sampled: out_valid=0 the next cycle; earliest new request the next cycle if nothing is in flight.
- Reset asserted mid-operation clears everything immediately; responses arriving after reset release for requests issued before reset are outside the contract.

## Structure
- Shared package: XLEN=32, INSTR_NOP=32'h0000_0013, fetch FSM enum (IDLE, RUN, FLUSH), queue-entry struct {pc, instr}.
- One sub-module: fetch_queue (synchronous FIFO, DEPTH entries, push/pop/flush, count output); counters and FSM live in fetch_unit.

## Test plan
- Reset release, memory ready always, latency 1, out_ready=1 -> requests at 0x0,0x4,0x8…; outputs pc 0x0,0x4,… with matching instr, 1 instr/cycle steady state.
- out_ready=0 with latency 3 -> at most DEPTH=4 requests outstanding+queued; imem_req_valid drops; no word lost when out_ready returns.
- Redirect to 0x100 with 3 requests in flight -> 3 responses discarded, FLUSH for their duration, next output pc=0x100.
- Redirect in same cycle as a response and a request handshake -> response not enqueued, request counted for dropping, first output pc = redirect_pc.
- redirect_pc=0xFFFF_FFFE -> fetch at 0xFFFF_FFFC then 0x0000_0000.
- Assert rst_n low mid-stream with full queue -> out_valid=0 and imem_req_addr=RESET_PC immediately, asynchronously.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_unit_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_e;

  // One buffered instruction together with the address it was fetched from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fq_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory and decode-side handshake bundle of the fetch unit.
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_resp_valid;
  logic [XLEN-1:0] imem_resp_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_instr;
  logic [XLEN-1:0] out_pc;

  // The fetch unit itself.
  modport master (
    output imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, out_ready
  );

  // Memory plus decoder as seen from outside.
  modport slave (
    input  imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc,
    output imem_req_ready, imem_resp_valid, imem_resp_data, out_ready
  );

endinterface

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of {pc, instr} entries with a single-cycle flush.
module fetch_queue
  import fetch_unit_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  fq_entry_t     push_entry,
  input  logic          pop,
  input  logic          flush,
  output fq_entry_t     head,
  output logic [CW-1:0] count
);

  fq_entry_t         mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;

  // Storage is data only; validity is carried entirely by count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  // Pointers and occupancy; flush drops every entry at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC generation, credit-limited memory requests,
// response buffering and redirect handling with in-flight response dropping.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  fetch_unit_if.master    bus,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e    state;
  fetch_state_e    state_nx;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic [XLEN-1:0] redirect_tgt;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   drop_nx;
  logic [CW-1:0]   q_count;
  logic [CW:0]     credit_used;
  logic            req_fire;
  logic            resp_drop;
  logic            resp_take;
  logic            push;
  logic            pop;
  logic            q_valid;
  fq_entry_t       head;
  fq_entry_t       push_entry;

  assign redirect_tgt = redirect_pc & {{(XLEN-2){1'b1}}, 2'b00};

  // Every request already owns a queue slot, so responses can never overflow.
  assign credit_used        = {1'b0, outstanding} + {1'b0, q_count};
  assign bus.imem_req_valid = (state == RUN) && (credit_used < (CW+1)'(DEPTH));
  assign bus.imem_req_addr  = fetch_pc;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

  assign resp_drop  = bus.imem_resp_valid && (drop_cnt != '0);
  assign resp_take  = bus.imem_resp_valid && (drop_cnt == '0);
  assign push       = resp_take && !redirect_valid;
  assign push_entry = {resp_pc, bus.imem_resp_data};

  assign q_valid       = (q_count != '0);
  assign pop           = q_valid && bus.out_ready;
  assign bus.out_valid = q_valid;
  assign bus.out_pc    = q_valid ? head.pc    : '0;
  assign bus.out_instr = q_valid ? head.instr : '0;

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (redirect_valid),
    .head       (head),
    .count      (q_count)
  );

  // Drops still owed; a redirect adds everything in flight, including this cycle's request.
  always_comb begin
    drop_nx = drop_cnt - CW'(resp_drop);
    if (redirect_valid) begin
      drop_nx = drop_cnt - CW'(resp_drop) + outstanding
                + CW'(req_fire) - CW'(resp_take);
    end
  end

  // Next-state logic: one idle cycle after reset, then fetch, pausing while stale words drain.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = RUN;
      RUN:     if (redirect_valid && (drop_nx != '0)) state_nx = FLUSH;
      FLUSH:   if (!redirect_valid && (drop_nx == '0)) state_nx = RUN;
      default: state_nx = IDLE;
    endcase
  end

  // State register and drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      drop_cnt <= '0;
    end else begin
      state    <= state_nx;
      drop_cnt <= drop_nx;
    end
  end

  // Outstanding-request counter; a redirect hands all in-flight requests to drop_cnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
    end else if (redirect_valid) begin
      outstanding <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(resp_take);
    end
  end

  // Request and response PCs advance independently; both wrap modulo 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_tgt;
      resp_pc  <= redirect_tgt;
    end else begin
      if (req_fire)  fetch_pc <= fetch_pc + XLEN'(4);
      if (resp_take) resp_pc  <= resp_pc + XLEN'(4);
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order, fixed-latency memory model.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          ep;
  } mreq_t;

  typedef struct {
    logic        rdy;
    logic        exp_rv;
    logic [31:0] exp_addr;
    logic        exp_ov;
    logic [31:0] exp_pc;
  } vec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          lat     = 1;
  int          cyc     = 0;
  int          epoch   = 0;
  int          viol    = 0;
  mreq_t       mq[$];
  logic [31:0] pc_log[$];
  logic [31:0] instr_log[$];
  logic [31:0] req_log[$];
  vec_t        vt[17];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic present();
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = mem_word(mq[0].addr);
    end else begin
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = '0;
    end
  endtask

  // Called after inputs have settled: samples handshakes, clocks, updates memory.
  task automatic step();
    logic        rf;
    logic        rp;
    logic [31:0] ra;
    rf = bus.imem_req_valid && bus.imem_req_ready;
    ra = bus.imem_req_addr;
    rp = bus.imem_resp_valid;
    if (rf) begin
      req_log.push_back(ra);
      foreach (mq[i]) if (mq[i].ep != epoch) viol++;
    end
    if (bus.out_valid && bus.out_ready) begin
      pc_log.push_back(bus.out_pc);
      instr_log.push_back(bus.out_instr);
    end
    @(posedge clk);
    #1;
    if (rp && mq.size() > 0) void'(mq.pop_front());
    if (rf) mq.push_back('{addr: ra, due: cyc + lat, ep: epoch});
    cyc++;
    present();
  endtask

  task automatic cyc1();
    #1;
    step();
  endtask

  task automatic clear_logs();
    pc_log.delete();
    instr_log.delete();
    req_log.delete();
  endtask

  task automatic do_reset(input int l);
    rst_n               = 1'b0;
    lat                 = l;
    redirect_valid      = 1'b0;
    redirect_pc         = '0;
    bus.out_ready       = 1'b0;
    bus.imem_req_ready  = 1'b1;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    mq.delete();
    clear_logs();
    viol  = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
    epoch = 0;
  endtask

  // Run pre cycles, redirect, then check the first three instructions delivered.
  task automatic redirect_test(input string nm, input int l, input int pre,
                               input logic [31:0] tgt, input logic exp_resp,
                               input logic [31:0] p0, input logic [31:0] p1,
                               input logic [31:0] p2);
    int k;
    do_reset(l);
    bus.out_ready = 1'b1;
    repeat (pre) cyc1();
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
    #1;
    chk({nm, "_resp_same_cycle"}, {31'b0, bus.imem_resp_valid}, {31'b0, exp_resp});
    chk({nm, "_req_same_cycle"}, {31'b0, bus.imem_req_valid}, 32'd1);
    step();
    epoch++;
    redirect_valid = 1'b0;
    clear_logs();
    #1;
    chk({nm, "_out_valid_after"}, {31'b0, bus.out_valid}, 32'd0);
    k = 0;
    while (pc_log.size() < 3 && k < 60) begin
      step();
      #1;
      k++;
    end
    chk({nm, "_out_count"}, 32'(pc_log.size()), 32'd3);
    if (pc_log.size() == 3) begin
      chk({nm, "_pc0"}, pc_log[0], p0);
      chk({nm, "_instr0"}, instr_log[0], mem_word(p0));
      chk({nm, "_pc1"}, pc_log[1], p1);
      chk({nm, "_instr1"}, instr_log[1], mem_word(p1));
      chk({nm, "_pc2"}, pc_log[2], p2);
      chk({nm, "_instr2"}, instr_log[2], mem_word(p2));
    end
    if (req_log.size() >= 2) begin
      chk({nm, "_req0"}, req_log[0], p0);
      chk({nm, "_req1"}, req_log[1], p1);
    end else begin
      chk({nm, "_req_count"}, 32'(req_log.size()), 32'd2);
    end
    chk({nm, "_no_req_during_flush"}, 32'(viol), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    // rdy, req_valid, req_addr, out_valid, out_pc -- latency-1 memory
    vt[0]  = '{1'b1, 1'b0, 32'h00, 1'b0, 32'h00};
    vt[1]  = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
    vt[2]  = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
    vt[3]  = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
    vt[4]  = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
    vt[5]  = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
    vt[6]  = '{1'b1, 1'b1, 32'h14, 1'b1, 32'h0C};
    vt[7]  = '{1'b0, 1'b1, 32'h18, 1'b1, 32'h10};
    vt[8]  = '{1'b0, 1'b1, 32'h1C, 1'b1, 32'h10};
    vt[9]  = '{1'b0, 1'b0, 32'h20, 1'b1, 32'h10};
    vt[10] = '{1'b0, 1'b0, 32'h20, 1'b1, 32'h10};
    vt[11] = '{1'b1, 1'b0, 32'h20, 1'b1, 32'h10};
    vt[12] = '{1'b1, 1'b1, 32'h20, 1'b1, 32'h14};
    vt[13] = '{1'b1, 1'b1, 32'h24, 1'b1, 32'h18};
    vt[14] = '{1'b1, 1'b1, 32'h28, 1'b1, 32'h1C};
    vt[15] = '{1'b1, 1'b1, 32'h2C, 1'b1, 32'h20};
    vt[16] = '{1'b1, 1'b1, 32'h30, 1'b1, 32'h24};

    // Reset state
    rst_n               = 1'b1;
    redirect_valid      = 1'b0;
    redirect_pc         = '0;
    bus.out_ready       = 1'b0;
    bus.imem_req_ready  = 1'b1;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
    chk("rst_req_addr", bus.imem_req_addr, 32'h0);
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_out_instr", bus.out_instr, 32'h0);
    chk("rst_out_pc", bus.out_pc, 32'h0);

    // Streaming and back-pressure, cycle by cycle
    do_reset(1);
    for (int i = 0; i < 17; i++) begin
      bus.out_ready = vt[i].rdy;
      #1;
      chk($sformatf("vec%0d_req_valid", i), {31'b0, bus.imem_req_valid}, {31'b0, vt[i].exp_rv});
      chk($sformatf("vec%0d_req_addr", i), bus.imem_req_addr, vt[i].exp_addr);
      chk($sformatf("vec%0d_out_valid", i), {31'b0, bus.out_valid}, {31'b0, vt[i].exp_ov});
      if (vt[i].exp_ov) begin
        chk($sformatf("vec%0d_out_pc", i), bus.out_pc, vt[i].exp_pc);
        chk($sformatf("vec%0d_out_instr", i), bus.out_instr, mem_word(vt[i].exp_pc));
      end
      step();
    end

    // Latency 3 with decode stalled: credit caps requests at DEPTH, nothing lost
    do_reset(3);
    repeat (25) cyc1();
    #1;
    chk("bp_req_total", 32'(req_log.size()), 32'd4);
    chk("bp_req_valid_low", {31'b0, bus.imem_req_valid}, 32'd0);
    chk("bp_out_valid", {31'b0, bus.out_valid}, 32'd1);
    chk("bp_head_pc", bus.out_pc, 32'h0);
    bus.out_ready = 1'b1;
    k = 0;
    while (pc_log.size() < 12 && k < 100) begin
      cyc1();
      k++;
    end
    chk("bp_drain_count", 32'(pc_log.size()), 32'd12);
    foreach (pc_log[i]) begin
      chk($sformatf("bp_pc%0d", i), pc_log[i], 32'(4 * i));
      chk($sformatf("bp_instr%0d", i), instr_log[i], mem_word(32'(4 * i)));
    end

    // Redirect with three requests in flight, no response that cycle
    redirect_test("redir3", 3, 3, 32'h0000_0100, 1'b0,
                  32'h100, 32'h104, 32'h108);
    // Redirect coinciding with a live response and a request handshake
    redirect_test("redir_same", 1, 2, 32'h0000_0200, 1'b1,
                  32'h200, 32'h204, 32'h208);
    // Misaligned target near the top of the address space wraps to zero
    redirect_test("redir_wrap", 1, 6, 32'hFFFF_FFFE, 1'b1,
                  32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004);

    // Asynchronous reset with a full queue
    do_reset(1);
    repeat (12) cyc1();
    #1;
    chk("midrst_pre_out_valid", {31'b0, bus.out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("midrst_req_addr", bus.imem_req_addr, 32'h0);
    chk("midrst_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
    chk("midrst_out_pc", bus.out_pc, 32'h0);
    chk("midrst_out_instr", bus.out_instr, 32'h0);
    mq.delete();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
